mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory request channel between the instruction-fetch requester (I) and the data-memory requester (D).
- Sits between the fetch/memory pipeline stages and the memory port.
- Grants one requester at a time and holds the grant until the downstream transaction completes.
- Registers the granted request payload, so the memory side sees a stable request. Routes the response back to the granted requester only.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width (both requesters and memory side).
- RR_MODE, 0, arbitration policy: 0 = fixed priority with D over I; 1 = round-robin.

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- i_valid  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_data_ok  out  1  fetch response valid
- i_rdata  out  DATA_W  fetch read data
- d_valid  in  1  data request
- d_addr  in  ADDR_W  data address
- d_write  in  1  1 = store
- d_strobe  in  DATA_W/8  byte enables, stores only
- d_wdata  in  DATA_W  store data
- d_data_ok  out  1  data response valid
- d_rdata  out  DATA_W  data read data
- m_valid  out  1  memory request
- m_addr  out  ADDR_W  memory address
- m_write  out  1  memory store
- m_strobe  out  DATA_W/8  memory byte enables
- m_wdata  out  DATA_W  memory store data
- m_data_ok  in  1  memory response valid; single beat
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state is BUSY

Behaviour:
- States:
  - IDLE: m_valid=0, busy=0.
  - BUSY: m_valid=1, busy=1.
- Reset values: state=IDLE, m_valid=0, all m_* payload registers 0, owner=I, last_grant=I, abandoned=0. Reset is honoured in any state and aborts an in-flight transaction with no response to either requester. Reset dominates all other events in the same cycle.
- IDLE → BUSY on a posedge where i_valid|d_valid. The grant is selected combinationally in that cycle:
  - Only one requester valid: grant that requester.
  - Both valid, RR_MODE=0: grant D.
  - Both valid, RR_MODE=1: grant the requester that is not last_grant. After reset, D wins the first contention.
- On the grant edge:
  - Latch owner and last_grant.
  - Latch m_addr, m_write, m_strobe and m_wdata from the winner. For I, m_write=0, m_strobe=0 and m_wdata=0.
  - Clear abandoned.
- Latency: a request visible in cycle N while IDLE gives m_valid=1 in cycle N+1.
- In BUSY, the m_* outputs stay constant until completion.
- BUSY → IDLE on a posedge where m_data_ok=1.
- Response routing is combinational in the m_data_ok cycle:
  - Owner I: i_data_ok = m_data_ok & ~abandoned, i_rdata = m_rdata.
  - Owner D: d_data_ok = m_data_ok & ~abandoned, d_rdata = m_rdata.
  - The non-owner's data_ok is always 0. Its rdata is 0.
- Abandonment: if the owner's valid is 0 in any BUSY cycle, set abandoned=1 on that edge (sticky until the next grant).
  - The downstream transaction still runs to m_data_ok.
  - Its response is swallowed; no data_ok is given to the owner.
  - This covers a fetch dropping its request on a pc redirect.
  - Abandonment is evaluated on the registered flag, so a drop in the completion cycle itself still delivers the response.
- Back-to-back: there is no arbitration in the completion cycle.
  - The earliest next m_valid is 2 cycles after an m_data_ok cycle.
  - The next grant is decided in the IDLE cycle after completion. A requester that received data_ok may assert a new request in that cycle.
- Requests arriving while BUSY are held by the requesters. The arbiter does not queue them.
- m_data_ok while IDLE is ignored: no data_ok out, no state change.
- Stores are issued only for D. The I path never drives m_write=1.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x8000_0000, m_data_ok asserted 3 cycles after m_valid with m_rdata=0x1234 → m_valid rises 1 cycle after i_valid, m_addr=0x8000_0000, m_write=0, i_data_ok=1 with i_rdata=0x1234 in one cycle, d_data_ok stays 0.
- Contention, RR_MODE=0: i_valid and d_valid both 1 for 3 transactions → all 3 granted to D. I is granted only after d_valid drops.
- Contention, RR_MODE=1: both held valid, with D store (addr 0x100, strobe 0x0F, wdata 0xAABB) → grant order D, I, D, I. m_strobe=0x0F, m_write=1 on D grants. Each next m_valid comes 2 cycles after the prior m_data_ok.
- Abandon: fetch granted, i_valid dropped 1 cycle later, m_data_ok 2 cycles after that → m_valid held through m_data_ok, i_data_ok never asserted. The next d request is granted normally.
- Reset mid-BUSY: assert reset while m_valid=1 → next cycle m_valid=0, busy=0, m_addr=0, no data_ok. A later m_data_ok while IDLE is ignored.
- Stability: in BUSY, change i_addr/d_wdata every cycle → m_addr/m_wdata are unchanged until completion.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory request channel between the instruction-fetch
// requester (I) and the data-memory requester (D).
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   i_valid, i_addr             fetch request
//   i_data_ok, i_rdata          fetch response
//   d_valid, d_addr, d_write,   data request (strobe/wdata used for stores only)
//   d_strobe, d_wdata
//   d_data_ok, d_rdata          data response
//   m_valid, m_addr, m_write,   registered memory request, stable while busy
//   m_strobe, m_wdata
//   m_data_ok, m_rdata          single-beat memory response
//   busy                        a transaction is in flight
//
// One requester is granted at a time and keeps the grant until m_data_ok.
// RR_MODE = 0 gives D fixed priority; RR_MODE = 1 alternates under contention.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned RR_MODE = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_data_ok,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_write,
   input  logic [DATA_W/8-1:0] d_strobe,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_data_ok,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic                m_write,
   output logic [DATA_W/8-1:0] m_strobe,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_data_ok,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                busy
);

   typedef enum logic {StIdle, StBusy} state_e;

   localparam logic OwnerI = 1'b0;
   localparam logic OwnerD = 1'b1;

   state_e state_q;
   logic   owner_q;
   logic   last_grant_q;
   logic   abandoned_q;
   logic   grant_is_d;
   logic   owner_valid;
   logic   resp_ok;

   // Grant selection, only consumed on an IDLE edge.
   always_comb begin
      grant_is_d = 1'b0;
      if (d_valid && !i_valid) begin
         grant_is_d = 1'b1;
      end else if (d_valid && i_valid) begin
         // Round-robin: whoever did not win last time; last_grant resets to I so D wins first.
         grant_is_d = (RR_MODE == 0) ? 1'b1 : (last_grant_q == OwnerI);
      end
   end

   assign owner_valid = (owner_q == OwnerD) ? d_valid : i_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         m_valid      <= 1'b0;
         m_addr       <= '0;
         m_write      <= 1'b0;
         m_strobe     <= '0;
         m_wdata      <= '0;
         owner_q      <= OwnerI;
         last_grant_q <= OwnerI;
         abandoned_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_valid || d_valid) begin
                  state_q      <= StBusy;
                  m_valid      <= 1'b1;
                  owner_q      <= grant_is_d;
                  last_grant_q <= grant_is_d;
                  abandoned_q  <= 1'b0;
                  if (grant_is_d) begin
                     m_addr   <= d_addr;
                     m_write  <= d_write;
                     m_strobe <= d_strobe;
                     m_wdata  <= d_wdata;
                  end else begin
                     // Fetches are always reads.
                     m_addr   <= i_addr;
                     m_write  <= 1'b0;
                     m_strobe <= '0;
                     m_wdata  <= '0;
                  end
               end
            end
            StBusy: begin
               // Owner withdrew: let memory finish but swallow the response.
               if (!owner_valid) begin
                  abandoned_q <= 1'b1;
               end
               if (m_data_ok) begin
                  state_q <= StIdle;
                  m_valid <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state_q == StBusy);

   // Uses the registered abandon flag, so a drop in the completion cycle still gets data.
   assign resp_ok   = busy && m_data_ok && !abandoned_q;
   assign i_data_ok = resp_ok && (owner_q == OwnerI);
   assign d_data_ok = resp_ok && (owner_q == OwnerD);
   assign i_rdata   = (owner_q == OwnerI) ? m_rdata : '0;
   assign d_rdata   = (owner_q == OwnerD) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Two instances share the stimulus: dut uses
// fixed priority (RR_MODE=0), dut_rr uses round-robin (RR_MODE=1).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [63:0] i_addr;
   logic        d_valid;
   logic [63:0] d_addr;
   logic        d_write;
   logic [7:0]  d_strobe;
   logic [63:0] d_wdata;
   logic        m_data_ok;
   logic [63:0] m_rdata;

   logic        i_data_ok, d_data_ok, m_valid, m_write, busy;
   logic [63:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [7:0]  m_strobe;

   logic        r_i_data_ok, r_d_data_ok, r_m_valid, r_m_write, r_busy;
   logic [63:0] r_i_rdata, r_d_rdata, r_m_addr, r_m_wdata;
   logic [7:0]  r_m_strobe;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_MODE(0)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_strobe(d_strobe),
      .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
      .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_strobe(m_strobe),
      .m_wdata(m_wdata), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .busy(busy)
   );

   mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_MODE(1)) dut_rr (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(r_i_data_ok), .i_rdata(r_i_rdata),
      .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_strobe(d_strobe),
      .d_wdata(d_wdata), .d_data_ok(r_d_data_ok), .d_rdata(r_d_rdata),
      .m_valid(r_m_valid), .m_addr(r_m_addr), .m_write(r_m_write), .m_strobe(r_m_strobe),
      .m_wdata(r_m_wdata), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .busy(r_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0;
      d_write = 1'b0; d_strobe = '0; d_wdata = '0; m_data_ok = 1'b0; m_rdata = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_write", m_write, 0);

      // Single fetch.
      i_valid = 1'b1; i_addr = 64'h8000_0000;
      check("fetch_no_same_cycle", m_valid, 0);
      tick();
      check("fetch_m_valid", m_valid, 1);
      check("fetch_m_addr", m_addr, 64'h8000_0000);
      check("fetch_m_write", m_write, 0);
      check("fetch_busy", busy, 1);
      tick(); tick(); tick();
      m_data_ok = 1'b1; m_rdata = 64'h1234;
      #1;
      check("fetch_i_ok", i_data_ok, 1);
      check("fetch_i_rdata", i_rdata, 64'h1234);
      check("fetch_d_ok", d_data_ok, 0);
      tick();
      m_data_ok = 1'b0; i_valid = 1'b0;
      #1;
      check("fetch_done_m_valid", m_valid, 0);
      check("fetch_done_i_ok", i_data_ok, 0);

      // Contention under fixed priority: D wins three times, I only after D drops.
      i_valid = 1'b1; i_addr = 64'h8000_0010;
      d_valid = 1'b1; d_addr = 64'h200; d_write = 1'b0; d_strobe = 8'h00; d_wdata = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("fp_m_valid", m_valid, 1);
         check("fp_m_addr_d", m_addr, 64'h200);
         m_data_ok = 1'b1; m_rdata = 64'h5000 + 64'(k);
         #1;
         check("fp_d_ok", d_data_ok, 1);
         check("fp_d_rdata", d_rdata, 64'h5000 + 64'(k));
         check("fp_i_ok", i_data_ok, 0);
         tick();
         m_data_ok = 1'b0;
         #1;
         check("fp_gap_m_valid", m_valid, 0);
      end
      d_valid = 1'b0;
      tick();
      check("fp_m_addr_i", m_addr, 64'h8000_0010);
      m_data_ok = 1'b1; m_rdata = 64'h77;
      #1;
      check("fp_i_ok_last", i_data_ok, 1);
      tick();
      m_data_ok = 1'b0; i_valid = 1'b0;
      // dut_rr has now granted D, I, D, I, so its next contention starts with D.

      // Round-robin contention with a D store.
      i_valid = 1'b1; i_addr = 64'h8000_0040;
      d_valid = 1'b1; d_addr = 64'h100; d_write = 1'b1; d_strobe = 8'h0F; d_wdata = 64'hAABB;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rr_m_valid", r_m_valid, 1);
         check("rr_m_addr", r_m_addr, (k % 2 == 0) ? 64'h100 : 64'h8000_0040);
         check("rr_m_write", r_m_write, (k % 2 == 0) ? 1 : 0);
         check("rr_m_strobe", r_m_strobe, (k % 2 == 0) ? 8'h0F : 8'h00);
         check("rr_m_wdata", r_m_wdata, (k % 2 == 0) ? 64'hAABB : 64'h0);
         m_data_ok = 1'b1; m_rdata = 64'h9900 + 64'(k);
         #1;
         check("rr_d_ok", r_d_data_ok, (k % 2 == 0) ? 1 : 0);
         check("rr_i_ok", r_i_data_ok, (k % 2 == 0) ? 0 : 1);
         tick();
         m_data_ok = 1'b0;
         #1;
         check("rr_gap_m_valid", r_m_valid, 0);
      end
      i_valid = 1'b0; d_valid = 1'b0; d_write = 1'b0; d_strobe = '0; d_wdata = '0;

      // Abandoned fetch: grant, drop one cycle later, complete two cycles after that.
      i_valid = 1'b1; i_addr = 64'h8000_0100;
      tick();
      check("ab_m_valid", m_valid, 1);
      tick();
      i_valid = 1'b0;
      tick();
      check("ab_hold_m_valid", m_valid, 1);
      tick();
      m_data_ok = 1'b1; m_rdata = 64'hDEAD;
      #1;
      check("ab_m_valid_at_ok", m_valid, 1);
      check("ab_i_ok", i_data_ok, 0);
      check("ab_d_ok", d_data_ok, 0);
      tick();
      m_data_ok = 1'b0;
      d_valid = 1'b1; d_addr = 64'h300;
      check("ab_idle", busy, 0);
      tick();
      check("ab_next_m_addr", m_addr, 64'h300);
      m_data_ok = 1'b1; m_rdata = 64'h42;
      #1;
      check("ab_next_d_ok", d_data_ok, 1);
      tick();
      m_data_ok = 1'b0; d_valid = 1'b0;

      // Reset while busy aborts the transaction.
      d_valid = 1'b1; d_addr = 64'h400;
      tick();
      check("rb_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0; d_valid = 1'b0;
      check("rb_m_valid", m_valid, 0);
      check("rb_busy_clr", busy, 0);
      check("rb_m_addr", m_addr, 0);
      check("rb_d_ok", d_data_ok, 0);
      m_data_ok = 1'b1; m_rdata = 64'hBEEF;
      #1;
      check("rb_idle_d_ok", d_data_ok, 0);
      check("rb_idle_i_ok", i_data_ok, 0);
      tick();
      m_data_ok = 1'b0;
      check("rb_idle_busy", busy, 0);
      check("rb_idle_m_valid", m_valid, 0);

      // Payload stability while busy.
      d_valid = 1'b1; d_addr = 64'h500; d_write = 1'b1; d_strobe = 8'hFF; d_wdata = 64'h11;
      tick();
      for (int k = 0; k < 3; k++) begin
         d_addr = 64'h600 + 64'(k); d_wdata = 64'(k); i_addr = 64'hC000 + 64'(k);
         tick();
         check("st_m_addr", m_addr, 64'h500);
         check("st_m_wdata", m_wdata, 64'h11);
      end
      m_data_ok = 1'b1;
      #1;
      check("st_d_ok", d_data_ok, 1);
      tick();
      m_data_ok = 1'b0; d_valid = 1'b0;
      check("st_done", m_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
